// File: rtl/fu_issue_scheduler_pkg.sv
// fu_issue_scheduler_pkg: FU types, RS geometry and issue grant packet shared by the issue scheduler.
package fu_issue_scheduler_pkg;
  localparam int RS_SIZE = 16;
  localparam int IDX_W = $clog2(RS_SIZE);
  typedef enum logic [2:0] {FU_ALU = 3'd0, FU_BR = 3'd1, FU_MULT = 3'd2, FU_LD = 3'd3, FU_ST = 3'd4} fu_type_e;
  typedef enum logic [1:0] {CLS_ALU, CLS_MULT, CLS_MEM, CLS_NONE} fu_class_e;
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } issue_gnt_t;
  function automatic fu_class_e fu_class(input logic [2:0] fu);
    return (fu == FU_ALU || fu == FU_BR) ? CLS_ALU :
           fu == FU_MULT ? CLS_MULT :
           (fu == FU_LD || fu == FU_ST) ? CLS_MEM : CLS_NONE;
  endfunction
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    return (a > 32'hFFFF_FFFF - 32'(b)) ? 32'hFFFF_FFFF : a + 32'(b);
  endfunction
endpackage

// File: rtl/fu_issue_scheduler_rr_picker.sv
// fu_issue_scheduler_rr_picker: first and second set request found scanning upward from ptr, wrapping.
module fu_issue_scheduler_rr_picker
  import fu_issue_scheduler_pkg::*;
(
  input  logic [RS_SIZE-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output issue_gnt_t         first,
  output issue_gnt_t         second
);
  logic [IDX_W-1:0] j;
  always_comb begin
    first = '0;
    second = '0;
    j = ptr;
    for (int k = 0; k < RS_SIZE; k++) begin
      j = ptr + IDX_W'(k);
      if (req[j] && !first.valid) first = '{1'b1, j};
      else if (req[j] && !second.valid) second = '{1'b1, j};
    end
  end
endmodule

// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: round-robin issue select for ALUs, one non-pipelined multiplier and one memory port.
// Define ISSUE_SCHED_STATS_EN to add saturating grant/stall counters.
module fu_issue_scheduler
  import fu_issue_scheduler_pkg::*;
#(
  parameter int NUM_ALU      = 2,
  parameter int MULT_LATENCY = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [RS_SIZE-1:0]              req_ready,
  input  logic [RS_SIZE-1:0][2:0]         req_fu,
  input  logic                            mem_port_busy,
  input  logic                            squash,
  output logic [NUM_ALU-1:0]              alu_gnt_valid,
  output logic [NUM_ALU-1:0][IDX_W-1:0]   alu_gnt_idx,
  output logic                            mult_gnt_valid,
  output logic [IDX_W-1:0]                mult_gnt_idx,
  output logic                            mem_gnt_valid,
  output logic [IDX_W-1:0]                mem_gnt_idx,
  output logic [RS_SIZE-1:0]              issue_mask,
  output logic                            mult_busy,
  output logic                            mult_done
`ifdef ISSUE_SCHED_STATS_EN
  ,
  output logic [31:0]                     stat_alu_grants,
  output logic [31:0]                     stat_mult_stall_cycles,
  output logic [31:0]                     stat_mem_stall_cycles
`endif
);
  localparam int CW = $clog2(MULT_LATENCY + 1);
  logic [IDX_W-1:0] alu_ptr, mult_ptr, mem_ptr;
  logic [CW-1:0] mult_cnt;
  logic [RS_SIZE-1:0] alu_req, mult_req, mem_req;
  issue_gnt_t a0, a1, m0, m1, e0, e1;
  logic [1:0] av;
  logic [1:0][IDX_W-1:0] ai;
  logic en, unused_second;
  for (genvar i = 0; i < RS_SIZE; i++) begin : g_cls
    assign alu_req[i] = req_ready[i] && fu_class(req_fu[i]) == CLS_ALU;
    assign mult_req[i] = req_ready[i] && fu_class(req_fu[i]) == CLS_MULT;
    assign mem_req[i] = req_ready[i] && fu_class(req_fu[i]) == CLS_MEM;
  end
  fu_issue_scheduler_rr_picker u_alu (.req(alu_req), .ptr(alu_ptr), .first(a0), .second(a1));
  fu_issue_scheduler_rr_picker u_mult (.req(mult_req), .ptr(mult_ptr), .first(m0), .second(m1));
  fu_issue_scheduler_rr_picker u_mem (.req(mem_req), .ptr(mem_ptr), .first(e0), .second(e1));
  assign unused_second = ^{m1, e1};
  // Reset low or squash blocks every grant so nothing is freed from the RS in those cycles
  assign en = reset && !squash;
  assign av[0] = en && a0.valid;
  assign av[1] = en && NUM_ALU == 2 && a1.valid;
  assign ai[0] = av[0] ? a0.idx : '0;
  assign ai[1] = av[1] ? a1.idx : '0;
  assign alu_gnt_valid = av[NUM_ALU-1:0];
  assign alu_gnt_idx = ai[NUM_ALU-1:0];
  assign mult_busy = mult_cnt != '0;
  assign mult_done = mult_cnt == CW'(1);
  assign mult_gnt_valid = en && !mult_busy && m0.valid;
  assign mult_gnt_idx = mult_gnt_valid ? m0.idx : '0;
  assign mem_gnt_valid = en && !mem_port_busy && e0.valid;
  assign mem_gnt_idx = mem_gnt_valid ? e0.idx : '0;
  always_comb begin
    issue_mask = '0;
    for (int k = 0; k < NUM_ALU; k++) if (alu_gnt_valid[k]) issue_mask[alu_gnt_idx[k]] = 1'b1;
    if (mult_gnt_valid) issue_mask[mult_gnt_idx] = 1'b1;
    if (mem_gnt_valid) issue_mask[mem_gnt_idx] = 1'b1;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_ptr <= '0;
      mult_ptr <= '0;
      mem_ptr <= '0;
      mult_cnt <= '0;
    end else begin
      if (av[1]) alu_ptr <= a1.idx + 1'b1;
      else if (av[0]) alu_ptr <= a0.idx + 1'b1;
      if (mult_gnt_valid) mult_ptr <= m0.idx + 1'b1;
      if (mem_gnt_valid) mem_ptr <= e0.idx + 1'b1;
      mult_cnt <= squash ? '0 : mult_gnt_valid ? CW'(MULT_LATENCY) : mult_busy ? mult_cnt - 1'b1 : mult_cnt;
    end
  end
`ifdef ISSUE_SCHED_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_alu_grants <= '0;
      stat_mult_stall_cycles <= '0;
      stat_mem_stall_cycles <= '0;
    end else begin
      stat_alu_grants <= sat_add(stat_alu_grants, 2'(av[0]) + 2'(av[1]));
      stat_mult_stall_cycles <= sat_add(stat_mult_stall_cycles, {1'b0, |mult_req && mult_busy});
      stat_mem_stall_cycles <= sat_add(stat_mem_stall_cycles, {1'b0, |mem_req && mem_port_busy});
    end
  end
`endif
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler: directed and random stimulus checked against a scan-order reference model.
module tb_fu_issue_scheduler;
  import fu_issue_scheduler_pkg::*;
  localparam int N = RS_SIZE;
  localparam int NA = 2;
  localparam int ML = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req_ready;
  logic [N-1:0][2:0] req_fu;
  logic mem_port_busy, squash;
  logic [NA-1:0] alu_gnt_valid;
  logic [NA-1:0][IDX_W-1:0] alu_gnt_idx;
  logic mult_gnt_valid, mem_gnt_valid, mult_busy, mult_done;
  logic [IDX_W-1:0] mult_gnt_idx, mem_gnt_idx;
  logic [N-1:0] issue_mask;
`ifdef ISSUE_SCHED_STATS_EN
  logic [31:0] stat_alu_grants, stat_mult_stall_cycles, stat_mem_stall_cycles;
`endif
  int checks = 0;
  int errors = 0;
  int m_alu_ptr, m_mult_ptr, m_mem_ptr, m_cnt;

  fu_issue_scheduler #(.NUM_ALU(NA), .MULT_LATENCY(ML)) dut (
    .clock(clock), .reset(reset), .req_ready(req_ready), .req_fu(req_fu),
    .mem_port_busy(mem_port_busy), .squash(squash),
    .alu_gnt_valid(alu_gnt_valid), .alu_gnt_idx(alu_gnt_idx),
    .mult_gnt_valid(mult_gnt_valid), .mult_gnt_idx(mult_gnt_idx),
    .mem_gnt_valid(mem_gnt_valid), .mem_gnt_idx(mem_gnt_idx),
    .issue_mask(issue_mask), .mult_busy(mult_busy), .mult_done(mult_done)
`ifdef ISSUE_SCHED_STATS_EN
    , .stat_alu_grants(stat_alu_grants), .stat_mult_stall_cycles(stat_mult_stall_cycles),
    .stat_mem_stall_cycles(stat_mem_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n-th (0-based) eligible entry met when walking ptr, ptr+1, ... around the RS; -1 if none
  function automatic int nth(input logic [N-1:0] elig, input int ptr, input int n);
    int seen = 0;
    for (int k = 0; k < N; k++) begin
      int j = (ptr + k) % N;
      if (elig[j]) begin
        if (seen == n) return j;
        seen++;
      end
    end
    return -1;
  endfunction

  task automatic tick();
    logic [N-1:0] ea, em, ee, mask;
    int a0, a1, mu, me;
    bit blocked;
    if (!reset) begin
      m_alu_ptr = 0; m_mult_ptr = 0; m_mem_ptr = 0; m_cnt = 0;
    end
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      ea[i] = req_ready[i] && (req_fu[i] inside {3'd0, 3'd1});
      em[i] = req_ready[i] && req_fu[i] == 3'd2;
      ee[i] = req_ready[i] && (req_fu[i] inside {3'd3, 3'd4});
    end
    blocked = !reset || squash;
    a0 = blocked ? -1 : nth(ea, m_alu_ptr, 0);
    a1 = blocked ? -1 : nth(ea, m_alu_ptr, 1);
    mu = (blocked || m_cnt != 0) ? -1 : nth(em, m_mult_ptr, 0);
    me = (blocked || mem_port_busy) ? -1 : nth(ee, m_mem_ptr, 0);
    mask = '0;
    if (a0 >= 0) mask[a0] = 1'b1;
    if (a1 >= 0) mask[a1] = 1'b1;
    if (mu >= 0) mask[mu] = 1'b1;
    if (me >= 0) mask[me] = 1'b1;
    chk("alu0_v", 32'(alu_gnt_valid[0]), 32'(a0 >= 0));
    chk("alu0_i", 32'(alu_gnt_idx[0]), a0 >= 0 ? a0 : 0);
    chk("alu1_v", 32'(alu_gnt_valid[1]), 32'(a1 >= 0));
    chk("alu1_i", 32'(alu_gnt_idx[1]), a1 >= 0 ? a1 : 0);
    chk("mult_v", 32'(mult_gnt_valid), 32'(mu >= 0));
    chk("mult_i", 32'(mult_gnt_idx), mu >= 0 ? mu : 0);
    chk("mem_v", 32'(mem_gnt_valid), 32'(me >= 0));
    chk("mem_i", 32'(mem_gnt_idx), me >= 0 ? me : 0);
    chk("mask", 32'(issue_mask), 32'(mask));
    chk("mult_busy", 32'(mult_busy), 32'(m_cnt != 0));
    chk("mult_done", 32'(mult_done), 32'(m_cnt == 1));
    @(posedge clock);
    if (!reset) begin
      m_alu_ptr = 0; m_mult_ptr = 0; m_mem_ptr = 0; m_cnt = 0;
    end else begin
      if (a1 >= 0) m_alu_ptr = (a1 + 1) % N;
      else if (a0 >= 0) m_alu_ptr = (a0 + 1) % N;
      if (mu >= 0) m_mult_ptr = (mu + 1) % N;
      if (me >= 0) m_mem_ptr = (me + 1) % N;
      m_cnt = squash ? 0 : mu >= 0 ? ML : m_cnt > 0 ? m_cnt - 1 : 0;
    end
    #1;
  endtask

  task automatic clear_reqs();
    req_ready = '0;
    for (int i = 0; i < N; i++) req_fu[i] = FU_ALU;
  endtask

  initial begin
    m_alu_ptr = 0; m_mult_ptr = 0; m_mem_ptr = 0; m_cnt = 0;
    clear_reqs();
    mem_port_busy = 1'b0;
    squash = 1'b0;
    @(posedge clock);
    #1;
    // reset held low with random requests
    for (int c = 0; c < 3; c++) begin
      req_ready = N'($urandom);
      for (int i = 0; i < N; i++) req_fu[i] = 3'($urandom_range(0, 4));
      #1 chk("rst_mask", 32'(issue_mask), 0);
      tick();
    end
    reset = 1'b1;
    clear_reqs();
    tick();
    tick();
    // ALU entries 3, 5, 9
    req_ready[3] = 1'b1; req_ready[5] = 1'b1; req_ready[9] = 1'b1;
    #1 chk("dir_alu0", 32'(alu_gnt_idx[0]), 3);
    chk("dir_alu1", 32'(alu_gnt_idx[1]), 5);
    chk("dir_alu_mask", 32'(issue_mask), 32'h28);
    tick();
    req_ready[3] = 1'b0; req_ready[5] = 1'b0;
    #1 chk("dir_alu_next", 32'(alu_gnt_idx[0]), 9);
    tick();
    clear_reqs();
    // multiply at 2 and 7
    req_fu[2] = FU_MULT; req_fu[7] = FU_MULT;
    req_ready[2] = 1'b1; req_ready[7] = 1'b1;
    #1 chk("dir_mult_first", 32'(mult_gnt_idx), 2);
    tick();
    req_ready[2] = 1'b0;
    for (int c = 1; c <= ML; c++) begin
      #1 chk("dir_mult_busy", 32'(mult_busy), 1);
      chk("dir_mult_done", 32'(mult_done), 32'(c == ML));
      tick();
    end
    #1 chk("dir_mult_second_v", 32'(mult_gnt_valid), 1);
    chk("dir_mult_second_i", 32'(mult_gnt_idx), 7);
    tick();
    clear_reqs();
    for (int c = 0; c < ML; c++) tick();
    // memory port wrap and busy hold
    req_fu[14] = FU_LD; req_ready[14] = 1'b1;
    tick();
    clear_reqs();
    req_fu[15] = FU_LD; req_fu[0] = FU_ST; req_ready[15] = 1'b1; req_ready[0] = 1'b1;
    #1 chk("dir_mem_wrap", 32'(mem_gnt_idx), 15);
    tick();
    req_ready[15] = 1'b0;
    req_fu[3] = FU_LD; req_ready[3] = 1'b1;
    mem_port_busy = 1'b1;
    #1 chk("dir_mem_busy", 32'(mem_gnt_valid), 0);
    tick();
    mem_port_busy = 1'b0;
    #1 chk("dir_mem_held", 32'(mem_gnt_idx), 0);
    tick();
    clear_reqs();
    // squash kills an in-flight multiply
    req_fu[4] = FU_MULT; req_ready[4] = 1'b1;
    #1 chk("dir_sq_grant", 32'(mult_gnt_idx), 4);
    tick();
    req_ready[4] = 1'b0;
    req_fu[6] = FU_MULT; req_ready[6] = 1'b1;
    tick();
    squash = 1'b1;
    #1 chk("dir_sq_block", 32'(mult_gnt_valid), 0);
    tick();
    squash = 1'b0;
    #1 chk("dir_sq_idle", 32'(mult_busy), 0);
    chk("dir_sq_regrant", 32'(mult_gnt_idx), 6);
    tick();
    clear_reqs();
    for (int c = 0; c < ML; c++) tick();
    // mixed classes in one cycle
    req_fu[0] = FU_ALU; req_fu[1] = FU_MULT; req_fu[2] = FU_ST; req_fu[3] = FU_BR;
    req_ready[3:0] = 4'hF;
    #1 chk("dir_mix_mask", 32'(issue_mask), 32'h000F);
    tick();
    clear_reqs();
    // squash in the last occupancy cycle still shows mult_done
    for (int c = 0; c < ML - 1; c++) tick();
    squash = 1'b1;
    #1 chk("dir_sq_done", 32'(mult_done), 1);
    tick();
    squash = 1'b0;
    tick();
    // random traffic
    for (int c = 0; c < 400; c++) begin
      req_ready = N'($urandom);
      for (int i = 0; i < N; i++) req_fu[i] = 3'($urandom_range(0, 5));
      mem_port_busy = $urandom_range(0, 9) < 3;
      squash = $urandom_range(0, 19) == 0;
      reset = $urandom_range(0, 49) != 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
